intsource: RTL and testbench

Interrupt request front end for the Nandy CPU, sitting directly upstream of the interrupt controller.
- Collects up to NSRC external request lines and synchronises them into the clock domain.
- Latches events as pending bits, applies a software mask, and drives the single `int` level the interrupt controller samples.
- On the controller's in-service rising edge, captures the highest-priority cause and retires its pending bit, so the handler at 0x7F00 can read which source fired.

---
 rtl/intsource_pkg.sv | 11 +
 rtl/intsource_prienc.sv | 24 ++
 rtl/intsource.sv | 125 ++++++++++++
 tb/tb_intsource.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intsource_pkg.sv
// Shared interrupt constants for the Nandy CPU: handler vector, default source count, cause width.
package intsource_pkg;

    localparam logic [15:0] INT_VECTOR   = 16'h7F00;
    localparam int          DEFAULT_NSRC = 8;

    function automatic int cause_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/intsource_prienc.sv
// prienc: fixed-priority encoder, lowest set index wins; any flags a non-empty request vector.
module prienc
    import intsource_pkg::*;
#(
    parameter int N  = DEFAULT_NSRC,
    parameter int CW = cause_width(N)
) (
    input  logic [N-1:0]  req,
    output logic [CW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = |req;
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = CW'(i);
            end
        end
    end

endmodule

// File: rtl/intsource.sv
// intsource: interrupt request front end (sync, pending, mask, cause capture); intr drives the controller's int.
// Optional level-sensitive sources are enabled with `define INTSOURCE_LEVEL_EN (adds the lmode input).
module intsource
    import intsource_pkg::*;
#(
    parameter int NSRC = DEFAULT_NSRC,
    parameter int CW   = cause_width(NSRC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq,
`ifdef INTSOURCE_LEVEL_EN
    input  logic [NSRC-1:0] lmode,
`endif
    input  logic            istatus,
    input  logic            mwe,
    input  logic [NSRC-1:0] mdata,
    input  logic            pclr,
    input  logic [NSRC-1:0] pdata,
    output logic            intr,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic [CW-1:0]   cause,
    output logic            cause_valid
);

    logic [NSRC-1:0] sync1_q, sync1_d;
    logic [NSRC-1:0] sync2_q, sync2_d;
    logic [NSRC-1:0] hist_q, hist_d;
    logic [1:0]      primed_q, primed_d;
    logic            ist_q, ist_d;
    logic            cap_q, cap_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            intr_q, intr_d;
    logic [CW-1:0]   cause_q, cause_d;
    logic            cause_valid_q, cause_valid_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] set_bits;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] retire;
    logic [NSRC-1:0] enabled;
    logic            drop_evt;
    logic [CW-1:0]   enc_idx;
    logic            enc_any;

    prienc #(
        .N  (NSRC),
        .CW (CW)
    ) u_prienc (
        .req (enabled),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        sync1_d  = irq;
        sync2_d  = sync1_q;
        primed_d = {primed_q[1'b0], 1'b1};
        // Until the sync chain holds real line values, history shadows it so a line
        // held high through reset is not mistaken for a fresh edge.
        hist_d   = primed_q[1] ? sync2_q : sync1_q;
        rise     = sync2_q & ~hist_q;
`ifdef INTSOURCE_LEVEL_EN
        set_bits = rise | (lmode & sync2_q);
`else
        set_bits = rise;
`endif
        ist_d    = istatus;
        cap_d    = istatus & ~ist_q;
        drop_evt = ist_q & ~istatus;

        enabled   = pending_q & mask_q;
        retire    = (cap_q && enc_any) ? (NSRC'(1) << enc_idx) : '0;
        clr_bits  = pclr ? pdata : '0;
        pending_d = (pending_q & ~clr_bits & ~retire) | set_bits;
        mask_d    = mwe ? mdata : mask_q;
        intr_d    = |enabled;

        cause_d       = cause_q;
        cause_valid_d = cause_valid_q;
        if (cap_q) begin
            cause_d       = enc_any ? enc_idx : '0;
            cause_valid_d = enc_any;
        end else if (drop_evt) begin
            cause_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            hist_q        <= '0;
            primed_q      <= '0;
            ist_q         <= 1'b0;
            cap_q         <= 1'b0;
            pending_q     <= '0;
            mask_q        <= '0;
            intr_q        <= 1'b0;
            cause_q       <= '0;
            cause_valid_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            hist_q        <= hist_d;
            primed_q      <= primed_d;
            ist_q         <= ist_d;
            cap_q         <= cap_d;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            intr_q        <= intr_d;
            cause_q       <= cause_d;
            cause_valid_q <= cause_valid_d;
        end
    end

    assign intr        = intr_q;
    assign pending     = pending_q;
    assign mask        = mask_q;
    assign cause       = cause_q;
    assign cause_valid = cause_valid_q;

endmodule

// File: tb/tb_intsource.sv
// Scoreboard bench for intsource: expectations are queued as stimulus is driven and drained after the DUT responds.
module tb_intsource;

    localparam int F_PENDING = 0;
    localparam int F_MASK    = 1;
    localparam int F_INTR    = 2;
    localparam int F_CAUSE   = 3;
    localparam int F_CVALID  = 4;

    logic       clk;
    logic       rst;
    logic [7:0] irq;
    logic [7:0] lmode;
    logic       istatus;
    logic       mwe;
    logic [7:0] mdata;
    logic       pclr;
    logic [7:0] pdata;
    logic       intr;
    logic [7:0] pending;
    logic [7:0] mask;
    logic [2:0] cause;
    logic       cause_valid;

    int assertCount;
    int failCount;

    string       expTag[$];
    int          expField[$];
    logic [31:0] expVal[$];

    intsource #(
        .NSRC (8),
        .CW   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
`ifdef INTSOURCE_LEVEL_EN
        .lmode       (lmode),
`endif
        .istatus     (istatus),
        .mwe         (mwe),
        .mdata       (mdata),
        .pclr        (pclr),
        .pdata       (pdata),
        .intr        (intr),
        .pending     (pending),
        .mask        (mask),
        .cause       (cause),
        .cause_valid (cause_valid)
    );

    // 100 MHz clock; the bench drives and samples 1 ns after each rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus sequence never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    // Single comparison point: every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] observedField(input int field);
        case (field)
            F_PENDING: return {24'b0, pending};
            F_MASK:    return {24'b0, mask};
            F_INTR:    return {31'b0, intr};
            F_CAUSE:   return {29'b0, cause};
            default:   return {31'b0, cause_valid};
        endcase
    endfunction

    task automatic pushExpect(input string tag, input int field, input logic [31:0] val);
        expTag.push_back(tag);
        expField.push_back(field);
        expVal.push_back(val);
    endtask

    task automatic drainScoreboard();
        string       tag;
        int          field;
        logic [31:0] val;
        while (expTag.size() != 0) begin
            tag   = expTag.pop_front();
            field = expField.pop_front();
            val   = expVal.pop_front();
            checkOutput(tag, observedField(field), val);
        end
    endtask

    // Advance the given number of rising edges, then compare everything queued.
    task automatic applyStimulus(input int edges);
        repeat (edges) @(posedge clk);
        #1;
        drainScoreboard();
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst     = 1'b0;
        irq     = 8'h00;
        lmode   = 8'h00;
        istatus = 1'b0;
        mwe     = 1'b0;
        mdata   = 8'h00;
        pclr    = 1'b0;
        pdata   = 8'h00;

        // Reset state
        pushExpect("rst_pending", F_PENDING, 32'h00);
        pushExpect("rst_mask",    F_MASK,    32'h00);
        pushExpect("rst_intr",    F_INTR,    32'h0);
        pushExpect("rst_cause",   F_CAUSE,   32'h0);
        pushExpect("rst_cvalid",  F_CVALID,  32'h0);
        applyStimulus(2);
        rst = 1'b1;
        applyStimulus(3);

        // Edge capture on source 3
        mwe = 1'b1; mdata = 8'hFF;
        pushExpect("ec_mask", F_MASK, 32'hFF);
        applyStimulus(1);
        mwe = 1'b0;
        irq = 8'h08;
        pushExpect("ec_pending", F_PENDING, 32'h08);
        pushExpect("ec_intr_lag", F_INTR, 32'h0);
        applyStimulus(3);
        irq = 8'h00;
        pushExpect("ec_intr", F_INTR, 32'h1);
        applyStimulus(1);
        istatus = 1'b1;
        pushExpect("ec_cause",   F_CAUSE,   32'h3);
        pushExpect("ec_cvalid",  F_CVALID,  32'h1);
        pushExpect("ec_retired", F_PENDING, 32'h00);
        applyStimulus(2);
        pushExpect("ec_intr_off", F_INTR, 32'h0);
        applyStimulus(1);

        // Release keeps cause
        istatus = 1'b0;
        pushExpect("rel_cvalid", F_CVALID, 32'h0);
        pushExpect("rel_cause",  F_CAUSE,  32'h3);
        applyStimulus(1);

        // Priority under mask 0C with pending 1,2,5
        mwe = 1'b1; mdata = 8'h0C;
        applyStimulus(1);
        mwe = 1'b0;
        irq = 8'h26;
        pushExpect("pm_pending", F_PENDING, 32'h26);
        applyStimulus(3);
        irq = 8'h00;
        pushExpect("pm_intr", F_INTR, 32'h1);
        applyStimulus(1);
        istatus = 1'b1;
        pushExpect("pm_cause",   F_CAUSE,   32'h2);
        pushExpect("pm_cvalid",  F_CVALID,  32'h1);
        pushExpect("pm_pending2", F_PENDING, 32'h22);
        applyStimulus(2);
        istatus = 1'b0;
        pushExpect("pm_intr_off", F_INTR, 32'h0);
        applyStimulus(1);
        istatus = 1'b1;
        pushExpect("pm_none_cvalid",  F_CVALID,  32'h0);
        pushExpect("pm_none_cause",   F_CAUSE,   32'h0);
        pushExpect("pm_none_pending", F_PENDING, 32'h22);
        applyStimulus(2);
        istatus = 1'b0;
        applyStimulus(1);

        // Clear race: new edge on bit 0 beats pclr, bit 1 still clears
        irq = 8'h01;
        applyStimulus(2);
        pclr = 1'b1; pdata = 8'h03;
        pushExpect("race_pending", F_PENDING, 32'h21);
        applyStimulus(1);
        pclr = 1'b0; pdata = 8'h00; irq = 8'h00;

        // Unmasking an already pending bit
        mwe = 1'b1; mdata = 8'h01;
        pushExpect("um_mask", F_MASK, 32'h01);
        pushExpect("um_intr_lag", F_INTR, 32'h0);
        applyStimulus(1);
        mwe = 1'b0;
        pushExpect("um_intr", F_INTR, 32'h1);
        applyStimulus(1);

        // Reset mid-operation with irq[7] held high
        mwe = 1'b1; mdata = 8'hFF; pclr = 1'b1; pdata = 8'hFF;
        applyStimulus(1);
        mwe = 1'b0; pclr = 1'b0; pdata = 8'h00;
        irq = 8'hA5;
        pushExpect("rm_pending", F_PENDING, 32'hA5);
        applyStimulus(3);
        irq = 8'h80;
        istatus = 1'b1;
        pushExpect("rm_cause",   F_CAUSE,   32'h0);
        pushExpect("rm_cvalid",  F_CVALID,  32'h1);
        pushExpect("rm_pending2", F_PENDING, 32'hA4);
        applyStimulus(2);
        #2;
        pushExpect("rm_async_pending", F_PENDING, 32'h00);
        pushExpect("rm_async_mask",    F_MASK,    32'h00);
        pushExpect("rm_async_intr",    F_INTR,    32'h0);
        pushExpect("rm_async_cause",   F_CAUSE,   32'h0);
        pushExpect("rm_async_cvalid",  F_CVALID,  32'h0);
        rst = 1'b0;
        #1;
        drainScoreboard();
        istatus = 1'b0;
        applyStimulus(2);
        rst = 1'b1;
        pushExpect("rm_held_no_edge", F_PENDING, 32'h00);
        applyStimulus(6);
        irq = 8'h00;
        applyStimulus(3);
        irq = 8'h80;
        pushExpect("rm_new_edge", F_PENDING, 32'h80);
        applyStimulus(3);
        irq = 8'h00;

`ifdef INTSOURCE_LEVEL_EN
        // Level-sensitive source 4: clears only stick after the line drops
        mwe = 1'b1; mdata = 8'hFF; pclr = 1'b1; pdata = 8'hFF;
        applyStimulus(1);
        mwe = 1'b0; pclr = 1'b0; pdata = 8'h00;
        lmode = 8'h10; irq = 8'h10;
        pushExpect("lv_set", F_PENDING, 32'h10);
        applyStimulus(3);
        pclr = 1'b1; pdata = 8'h10;
        pushExpect("lv_reassert", F_PENDING, 32'h10);
        applyStimulus(1);
        pclr = 1'b0; pdata = 8'h00;
        irq = 8'h00;
        applyStimulus(3);
        pclr = 1'b1; pdata = 8'h10;
        pushExpect("lv_cleared", F_PENDING, 32'h00);
        applyStimulus(1);
        pclr = 1'b0; pdata = 8'h00;
        pushExpect("lv_stays_clear", F_PENDING, 32'h00);
        applyStimulus(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
